fb_triple_buffer_ctrl: RTL

FB_TRIPLE_BUFFER_CTRL -- requirements
Module: fb_triple_buffer_ctrl

---
 rtl/fb_triple_buffer_ctrl_pkg.sv | 18 +
 rtl/fb_bank_rotator.sv | 79 +++++++
 rtl/fb_triple_buffer_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/fb_triple_buffer_ctrl_pkg.sv
// Shared constants for the triple-buffered frame store.
// Used by the buffer controller and by the capture and VGA blocks, so that
// every block agrees on the bank size, the bank-index width and the
// bank roles that hold after reset.
package fb_triple_buffer_ctrl_pkg;

  // Words per frame bank: 320x240 pixels, one 12-bit word per pixel
  localparam int unsigned FRAME_WORDS = 76800;
  localparam int unsigned BANK_W      = 2;

  typedef logic [BANK_W-1:0] bank_t;

  // Bank roles after reset
  localparam bank_t RESET_W_BANK = 2'd0;
  localparam bank_t RESET_R_BANK = 2'd1;
  localparam bank_t RESET_D_BANK = 2'd2;

endpackage

// File: rtl/fb_bank_rotator.sv
// Bank role rotator for the triple buffer.
// Holds the write (W), ready (R) and display (D) bank indices and the
// ready_valid flag, and updates them on camera frame completion and on the
// start of VGA vsync. The three indices are always a permutation of {0,1,2}.
// Ports:
//   clk25, resetn  - clock and asynchronous active-low reset
//   frame_done     - single-cycle pulse: camera finished a frame
//   vga_vsync      - active-low vsync level from the VGA timing generator
//   w_bank, r_bank, d_bank, ready_valid - current bank roles
//   promote        - this cycle promotes the ready bank to display
//   drop           - this cycle discards a completed, undisplayed frame
module fb_bank_rotator
  import fb_triple_buffer_ctrl_pkg::*;
(
  input  logic  clk25,
  input  logic  resetn,
  input  logic  frame_done,
  input  logic  vga_vsync,
  output bank_t w_bank,
  output bank_t r_bank,
  output bank_t d_bank,
  output logic  ready_valid,
  output logic  promote,
  output logic  drop
);

  logic  vsync_q;
  logic  vsync_start;
  bank_t w_next, r_next, d_next;
  logic  rv_next;

  // Falling edge of the active-low vsync; history resets high so that a
  // vsync already low at reset release still counts as a start.
  assign vsync_start = vsync_q & ~vga_vsync;

  always_comb begin
    w_next  = w_bank;
    r_next  = r_bank;
    d_next  = d_bank;
    rv_next = ready_valid;
    promote = 1'b0;
    drop    = frame_done & ready_valid;
    if (frame_done && vsync_start) begin
      // Finished frame goes straight to display, old display becomes
      // ready-but-stale, old ready becomes the new write target.
      w_next  = r_bank;
      r_next  = d_bank;
      d_next  = w_bank;
      rv_next = 1'b0;
      promote = 1'b1;
    end else if (frame_done) begin
      w_next  = r_bank;
      r_next  = w_bank;
      rv_next = 1'b1;
    end else if (vsync_start && ready_valid) begin
      d_next  = r_bank;
      r_next  = d_bank;
      rv_next = 1'b0;
      promote = 1'b1;
    end
  end

  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      w_bank      <= RESET_W_BANK;
      r_bank      <= RESET_R_BANK;
      d_bank      <= RESET_D_BANK;
      ready_valid <= 1'b0;
      vsync_q     <= 1'b1;
    end else begin
      w_bank      <= w_next;
      r_bank      <= r_next;
      d_bank      <= d_next;
      ready_valid <= rv_next;
      vsync_q     <= vga_vsync;
    end
  end

endmodule

// File: rtl/fb_triple_buffer_ctrl.sv
// Triple-buffer controller for a camera-to-VGA frame store.
// Translates camera write offsets and VGA read offsets into absolute frame
// RAM addresses inside the current write and display banks, and counts
// displayed and dropped frames. Offsets are not range checked.
// Ports:
//   clk25, resetn      - 25 MHz clock, asynchronous active-low reset
//   cam_we, cam_addr   - camera write strobe and pixel offset
//   cam_frame_done     - pulse on the last pixel of a camera frame
//   vga_vsync          - active-low vsync
//   frame_addr         - VGA read offset
//   mem_wr_addr, mem_we, mem_rd_addr - registered frame RAM controls
//   drop_count         - saturating count of discarded frames
//   show_count         - wrapping count of frames promoted to display
module fb_triple_buffer_ctrl
  import fb_triple_buffer_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = fb_triple_buffer_ctrl_pkg::FRAME_WORDS,
  parameter int unsigned ADDR_W      = 18
) (
  input  logic              clk25,
  input  logic              resetn,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic              cam_frame_done,
  input  logic              vga_vsync,
  input  logic [ADDR_W-1:0] frame_addr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [7:0]        drop_count,
  output logic [15:0]       show_count
);

  bank_t             w_bank, r_bank, d_bank;
  logic              ready_valid;
  logic              promote, drop;
  logic [ADDR_W-1:0] base_w, base_d;

  fb_bank_rotator u_rotator (
    .clk25       (clk25),
    .resetn      (resetn),
    .frame_done  (cam_frame_done),
    .vga_vsync   (vga_vsync),
    .w_bank      (w_bank),
    .r_bank      (r_bank),
    .d_bank      (d_bank),
    .ready_valid (ready_valid),
    .promote     (promote),
    .drop        (drop)
  );

  assign base_w = ADDR_W'(w_bank) * ADDR_W'(FRAME_WORDS);
  assign base_d = ADDR_W'(d_bank) * ADDR_W'(FRAME_WORDS);

  // Addresses use the bank roles before this cycle's event, so the cycle
  // carrying frame_done still writes into the old write bank.
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      mem_wr_addr <= '0;
      mem_we      <= 1'b0;
      mem_rd_addr <= '0;
      drop_count  <= '0;
      show_count  <= '0;
    end else begin
      mem_wr_addr <= base_w + cam_addr;
      mem_we      <= cam_we;
      mem_rd_addr <= base_d + frame_addr;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 8'd1;
      if (promote) show_count <= show_count + 16'd1;
    end
  end

endmodule
